// File: rtl/hazard_tracker.sv
// RV32I hazard tracker: per-stage rd scoreboard, forwarding selects and load-use stall.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_EN.
module hazard_tracker #(
  parameter int DEPTH = 2,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          id_instr,
  input  logic                 id_valid,
  input  logic                 adv,
  input  logic                 flush,
  output logic                 stall,
  output logic [SELW-1:0]      fwd_rs1,
  output logic [SELW-1:0]      fwd_rs2,
  output logic [2*DEPTH-1:0]   dep_map,
  output logic [15:0]          stall_count
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } entry_t;

  // Index 0 is the EX stage (stage 1); index DEPTH-1 is the oldest.
  entry_t entry_q [DEPTH];
  entry_t entry_d [DEPTH];

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic       reads_rs1, reads_rs2, writes_rd, is_load;
  logic       rs1_hit [DEPTH];
  logic       rs2_hit [DEPTH];
  logic       unused_instr_bits;

  assign opcode = id_instr[6:0];
  assign rd     = id_instr[11:7];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];
  assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12]};

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    reads_rs1 = 1'b0;
    reads_rs2 = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OP_REG: begin
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
        writes_rd = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        reads_rs1 = 1'b1;
        reads_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        reads_rs1 = 1'b1;
        writes_rd = 1'b1;
      end
      OP_JAL, OP_LUI, OP_AUIPC: writes_rd = 1'b1;
      default: ;
    endcase
  end

  assign is_load = (opcode == OP_LOAD);

  // A zero source register never matches, so an x0 writer is tracked but inert.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      rs1_hit[k] = entry_q[k].valid && (entry_q[k].rd == rs1) && (rs1 != 5'd0) && reads_rs1;
      rs2_hit[k] = entry_q[k].valid && (entry_q[k].rd == rs2) && (rs2 != 5'd0) && reads_rs2;
    end
  end

  // Walk oldest to youngest so the youngest match is the last one written.
  always_comb begin
    dep_map = '0;
    fwd_rs1 = '0;
    fwd_rs2 = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      dep_map[2*k]   = rs1_hit[k];
      dep_map[2*k+1] = rs2_hit[k];
      if (rs1_hit[k]) fwd_rs1 = SELW'(k + 1);
      if (rs2_hit[k]) fwd_rs2 = SELW'(k + 1);
    end
  end

  assign stall = id_valid && !flush && entry_q[0].valid && entry_q[0].is_load &&
                 (rs1_hit[0] || rs2_hit[0]);

  always_comb begin
    entry_d = entry_q;
    if (adv) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        entry_d[k] = entry_q[k-1];
      end
      if (id_valid && !stall && !flush && writes_rd) begin
        entry_d[0] = '{valid: 1'b1, rd: rd, is_load: is_load};
      end else begin
        entry_d[0] = '0;
      end
    end
  end

  // NOTE: the scoreboard is a handful of flops rather than a RAM, so every
  // field is reset; this is what forces all outputs to 0 while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        entry_q[k] <= '0;
      end
    end else begin
      entry_q <= entry_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_count_q, stall_count_d;

  // Counts only cycles where the stall actually takes effect, saturating at max.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && adv && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = '0;
`endif

endmodule
